// File: rtl/ram_pkg.sv
// Shared constants and types for the data-RAM arbiter slice.
package ram_pkg;
  localparam int RAM_ADDR_W = 9;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_DEPTH  = 512;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_IO  = 1'b1
  } port_e;

  // Outstanding read: valid plus the port the registered RAM data belongs to.
  typedef struct packed {
    logic  valid;
    port_e port;
  } rd_tag_t;

  typedef struct packed {
    logic  valid;
    port_e owner;
  } lock_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with its priority pointer register.
module rr_arb2
  import ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] gnt,
  output port_e      rr_ptr
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (rr_ptr == PORT_IO) ? 2'b10 : 2'b01;
    end
  end

  // After a grant the losing side becomes favoured; hold freezes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= PORT_CPU;
    end else if ((|gnt) && !hold) begin
      rr_ptr <= gnt[0] ? PORT_IO : PORT_CPU;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of the 512x32 synchronous data RAM.
// Optional bus locking for atomic read-modify-write: RAM_ARB_LOCK_EN.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // Handshake: a requester raises req with stable we/addr/wdata and keeps
  // them until gnt is seen in the same cycle; gnt is the single-cycle accept.
  // A granted read answers with rvalid exactly one cycle later.
  logic [1:0] req_m;
  logic [1:0] gnt;
  logic       hold;
  logic       win;
  port_e      win_port;
  logic       sel_we;
  rd_tag_t    rd_tag;

`ifdef RAM_ARB_LOCK_EN
  lock_t      lock_q;
  logic       sel_lock;

  always_comb begin
    req_m = {m1_req, m0_req} & {2{rst_n}};
    hold  = lock_q.valid;
    if (lock_q.valid) begin
      req_m = req_m & ((lock_q.owner == PORT_IO) ? 2'b10 : 2'b01);
    end
  end

  assign sel_lock = (win_port == PORT_IO) ? m1_lock : m0_lock;

  // A locked grant claims the bus; the owner's first unlocked grant frees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= '{valid: 1'b0, owner: PORT_CPU};
    end else if (win) begin
      if (sel_lock) begin
        lock_q <= '{valid: 1'b1, owner: win_port};
      end else begin
        lock_q.valid <= 1'b0;
      end
    end
  end
`else
  // Reset gating keeps grants and RAM strobes quiet while rst_n is low.
  always_comb begin
    req_m = {m1_req, m0_req} & {2{rst_n}};
    hold  = 1'b0;
  end
`endif

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_m),
    .hold   (hold),
    .gnt    (gnt),
    .rr_ptr ()
  );

  assign win      = |gnt;
  assign win_port = gnt[1] ? PORT_IO : PORT_CPU;
  assign m0_gnt   = gnt[0];
  assign m1_gnt   = gnt[1];

  assign sel_we    = (win_port == PORT_IO) ? m1_we    : m0_we;
  assign ram_addr  = (win_port == PORT_IO) ? m1_addr  : m0_addr;
  assign ram_wdata = (win_port == PORT_IO) ? m1_wdata : m0_wdata;
  assign ram_read  = win & ~sel_we;
  assign ram_write = win & sel_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_tag <= '{valid: 1'b0, port: PORT_CPU};
    end else begin
      rd_tag <= '{valid: ram_read, port: win_port};
    end
  end

  assign m0_rvalid = rd_tag.valid && (rd_tag.port == PORT_CPU);
  assign m1_rvalid = rd_tag.valid && (rd_tag.port == PORT_IO);
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, reference arbitration model with an
// expected read queue, and directed plus randomized scenarios.
module tb_ram_arbiter;
  import ram_pkg::*;

  localparam int AW = RAM_ADDR_W;
  localparam int DW = RAM_DATA_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT connections ----------------
  logic          req_a   [2];
  logic          we_a    [2];
  logic [AW-1:0] addr_a  [2];
  logic [DW-1:0] wdata_a [2];
  logic          lock_a  [2];

  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_read, ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  ram_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (req_a[0]),
    .m0_we     (we_a[0]),
    .m0_addr   (addr_a[0]),
    .m0_wdata  (wdata_a[0]),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (req_a[1]),
    .m1_we     (we_a[1]),
    .m1_addr   (addr_a[1]),
    .m1_wdata  (wdata_a[1]),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
`ifdef RAM_ARB_LOCK_EN
    .m0_lock   (lock_a[0]),
    .m1_lock   (lock_a[1]),
`endif
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // ---------------- behavioural synchronous RAM ----------------
  logic [DW-1:0] ram_mem [RAM_DEPTH];
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_addr] <= ram_wdata;
    if (ram_read)  ram_rdata <= ram_mem[ram_addr];
  end

  // ---------------- reference model + scoreboard ----------------
  int            errors = 0;
  int            checks = 0;
  logic [DW:0]   exp_q[$];          // {port, data} of the read due next cycle
  logic [DW-1:0] ref_mem [RAM_DEPTH];
  int            favoured = 0;
  bit            locked   = 1'b0;
  int            owner    = 0;

  function automatic int model_winner();
    bit e0, e1;
    e0 = req_a[0];
    e1 = req_a[1];
`ifdef RAM_ARB_LOCK_EN
    if (locked) begin
      if (owner == 0) e1 = 1'b0;
      else            e0 = 1'b0;
    end
`endif
    if (e0 && e1) return favoured;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    logic [DW:0] e;
    bit exp_rv0, exp_rv1;
    if (!rst_n) begin
      checks++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_read, ram_write} !== 6'b0) begin
        errors++;
        $display("FAIL reset_quiet: gnt/rvalid/strobes=%b required 000000",
                 {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_read, ram_write});
      end
      exp_q.delete();
      favoured = 0;
      locked   = 1'b0;
    end else begin
      exp_rv0 = 1'b0;
      exp_rv1 = 1'b0;
      e = '0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_rv0 = ~e[DW];
        exp_rv1 = e[DW];
      end
      checks++;
      if ({m0_rvalid, m1_rvalid} !== {exp_rv0, exp_rv1}) begin
        errors++;
        $display("FAIL rvalid: m0/m1=%b%b required %b%b", m0_rvalid, m1_rvalid, exp_rv0, exp_rv1);
      end
      if (exp_rv0 || exp_rv1) begin
        checks++;
        if ((exp_rv0 ? m0_rdata : m1_rdata) !== e[DW-1:0]) begin
          errors++;
          $display("FAIL rdata: got %h required %h", exp_rv0 ? m0_rdata : m1_rdata, e[DW-1:0]);
        end
      end

      w = model_winner();
      checks++;
      if ({m1_gnt, m0_gnt} !== {w == 1, w == 0}) begin
        errors++;
        $display("FAIL gnt: m1/m0=%b%b required %b%b", m1_gnt, m0_gnt, w == 1, w == 0);
      end
      checks++;
      if ({ram_read, ram_write} !== {w >= 0 && !we_a[w < 0 ? 0 : w], w >= 0 && we_a[w < 0 ? 0 : w]}) begin
        errors++;
        $display("FAIL ram_strobe: read/write=%b%b winner=%0d", ram_read, ram_write, w);
      end
      if (w >= 0) begin
        checks++;
        if (ram_addr !== addr_a[w]) begin
          errors++;
          $display("FAIL ram_addr: got %0d required %0d", ram_addr, addr_a[w]);
        end
        if (we_a[w]) begin
          checks++;
          if (ram_wdata !== wdata_a[w]) begin
            errors++;
            $display("FAIL ram_wdata: got %h required %h", ram_wdata, wdata_a[w]);
          end
          ref_mem[addr_a[w]] = wdata_a[w];
        end else begin
          exp_q.push_back({w[0], ref_mem[addr_a[w]]});
        end
        if (!locked) favoured = 1 - w;
`ifdef RAM_ARB_LOCK_EN
        if (lock_a[w]) begin
          locked = 1'b1;
          owner  = w;
        end else begin
          locked = 1'b0;
        end
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int p, input bit req, input bit we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data, input bit lk);
    req_a[p]   = req;
    we_a[p]    = we;
    addr_a[p]  = addr;
    wdata_a[p] = data;
    lock_a[p]  = lk;
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    drive(0, 1'b1, 1'b0, 9'd1, '0, 1'b0);
    drive(1, 1'b1, 1'b0, 9'd2, '0, 1'b0);
    repeat (2) next_cycle();
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs: %b required 0000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL first_gnt: m1/m0=%b%b required 01", m1_gnt, m0_gnt);
    end
    next_cycle();
    checks++;
    if (dut.u_arb.rr_ptr !== PORT_IO) begin
      errors++;
      $display("FAIL rr_ptr_after_first: got %0d required 1", dut.u_arb.rr_ptr);
    end
    idle_all();
    next_cycle();
  endtask

  task automatic test_write_read();
    drive(0, 1'b1, 1'b1, 9'd144, 32'hDEADBEEF, 1'b0);
    next_cycle();
    drive(0, 1'b1, 1'b0, 9'd144, '0, 1'b0);
    next_cycle();
    idle_all();
    #1;
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL write_read: rv=%b%b data=%h required 10 deadbeef", m0_rvalid, m1_rvalid, m0_rdata);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int prev;
    drive(0, 1'b1, 1'b1, 9'd10, 32'hA0A0_0010, 1'b0);
    drive(1, 1'b1, 1'b1, 9'd20, 32'hB1B1_0020, 1'b0);
    next_cycle();
    next_cycle();
    drive(0, 1'b1, 1'b0, 9'd10, '0, 1'b0);
    drive(1, 1'b1, 1'b0, 9'd20, '0, 1'b0);
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ((m0_gnt ^ m1_gnt) !== 1'b1 || (prev == 1 && !m0_gnt) || (prev == 0 && !m1_gnt)) begin
        errors++;
        $display("FAIL alternate: cycle %0d m1/m0=%b%b prev=%0d", i, m1_gnt, m0_gnt, prev);
      end
      prev = m1_gnt ? 1 : 0;
      next_cycle();
    end
    idle_all();
    next_cycle();
  endtask

  task automatic test_io_write_cpu_read();
    drive(1, 1'b1, 1'b1, 9'd247, 32'h12345678, 1'b0);
    #1;
    checks++;
    if (m1_gnt !== 1'b1) begin
      errors++;
      $display("FAIL io_write_gnt: got %b required 1", m1_gnt);
    end
    next_cycle();
    drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(0, 1'b1, 1'b0, 9'd247, '0, 1'b0);
    next_cycle();
    idle_all();
    #1;
    checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h12345678}) begin
      errors++;
      $display("FAIL io_then_cpu: rv=%b data=%h required 1 12345678", m0_rvalid, m0_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    drive(0, 1'b1, 1'b0, 9'd144, '0, 1'b0);
    next_cycle();
    idle_all();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_read: rvalid=%b%b required 00", m0_rvalid, m1_rvalid);
    end
    repeat (2) next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checks++;
      if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL stray_rvalid: cycle %0d rvalid=%b%b required 00", i, m0_rvalid, m1_rvalid);
      end
    end
  endtask

`ifdef RAM_ARB_LOCK_EN
  task automatic test_lock();
    drive(0, 1'b1, 1'b0, 9'd5, '0, 1'b1);
    next_cycle();
    drive(0, 1'b0, 1'b0, 9'd5, '0, 1'b0);
    drive(1, 1'b1, 1'b0, 9'd7, '0, 1'b0);
    #1;
    checks++;
    if (m1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL lock_stall_idle: m1_gnt=%b required 0", m1_gnt);
    end
    next_cycle();
    drive(0, 1'b1, 1'b1, 9'd5, 32'h0000_0055, 1'b0);
    #1;
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL lock_stall_both: m1/m0=%b%b required 01", m1_gnt, m0_gnt);
    end
    next_cycle();
    drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    checks++;
    if (m1_gnt !== 1'b1) begin
      errors++;
      $display("FAIL lock_release: m1_gnt=%b required 1", m1_gnt);
    end
    next_cycle();
    idle_all();
    next_cycle();
  endtask
`endif

  task automatic test_random();
    bit g0, g1;
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_a[p] && $urandom_range(0, 2) != 0) begin
          drive(p, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
`ifdef RAM_ARB_LOCK_EN
                1'($urandom_range(0, 7) == 0)
`else
                1'b0
`endif
               );
        end
      end
      @(negedge clk);
      g0 = m0_gnt;
      g1 = m1_gnt;
      next_cycle();
      if (g0) req_a[0] = 1'b0;
      if (g1) req_a[1] = 1'b0;
    end
    idle_all();
    repeat (4) next_cycle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    ram_rdata = '0;
    idle_all();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_io_write_cpu_read();
    test_reset_mid_read();
`ifdef RAM_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
